ritc_phase_scan_controller: RTL

// - Initiator side of the RITC phase scan: steps the MMCM fine phase shift, requests sampling,

---
 rtl/ritc_phase_scan_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ritc_phase_scan_controller.sv
// ritc_phase_scan_controller: steps MMCM fine phase, counts ones on one selected RITC bit per step, streams (step, count); define SCAN_AUTO_RETURN_EN to unwind the phase after the scan
module ritc_phase_scan_controller #(
  parameter int NSTEPS    = 448,
  parameter int STEP_BITS = 9,
  parameter int NSAMPLES  = 256,
  parameter int CNT_BITS  = 9,
  parameter int SETTLE    = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 user_clk_i,
  input  logic                 user_rst_i,
  input  logic                 start_i,
  input  logic [5:0]           sel_i,
  input  logic [2:0]           clk_q_i,
  input  logic [11:0]          ch0_q_i,
  input  logic [11:0]          ch1_q_i,
  input  logic [11:0]          ch2_q_i,
  input  logic                 vcdl_q_i,
  output logic                 user_scan_o,
  output logic                 ps_en_o,
  output logic                 ps_incdec_o,
  input  logic                 ps_done_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [STEP_BITS-1:0] res_step_o,
  output logic [CNT_BITS-1:0]  res_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int CW = $clog2(TIMEOUT + NSAMPLES + SETTLE + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_REPORT, S_SHIFT, S_WAIT, S_DONE, S_ERR
`ifdef SCAN_AUTO_RETURN_EN
    , S_RET_SHIFT, S_RET_WAIT
`endif
  } state_t;
  state_t state, state_nx;
  logic [CW-1:0] cyc;
  logic [STEP_BITS-1:0] step;
  logic [CNT_BITS-1:0] cnt;
  logic [5:0] sel;
  logic err, launch, tmo, last;
  logic [63:0] bits;
  assign bits = {24'd0, vcdl_q_i, ch2_q_i, ch1_q_i, ch0_q_i, clk_q_i};
  assign tmo = cyc == CW'(TIMEOUT - 1);
  assign last = step == STEP_BITS'(NSTEPS - 1);
  assign res_step_o = step;
  assign res_count_o = cnt;
  assign err_o = err;
  // Next state and Moore-style control outputs
  always_comb begin
    state_nx = state;
    launch = 1'b0;
    user_scan_o = 1'b0;
    ps_en_o = 1'b0;
    ps_incdec_o = 1'b0;
    res_valid_o = 1'b0;
    done_o = 1'b0;
    busy_o = 1'b1;
    case (state)
      S_IDLE, S_ERR: begin
        busy_o = 1'b0;
        launch = start_i;
        state_nx = start_i ? S_SETTLE : state;
      end
      S_SETTLE: state_nx = cyc == CW'(SETTLE - 1) ? S_SAMPLE : state;
      S_SAMPLE: begin
        user_scan_o = cyc == '0;
        state_nx = cyc == CW'(NSAMPLES - 1) ? S_REPORT : state;
      end
      S_REPORT: begin
        res_valid_o = 1'b1;
`ifdef SCAN_AUTO_RETURN_EN
        if (res_ready_i) state_nx = !last ? S_SHIFT : step == '0 ? S_DONE : S_RET_SHIFT;
`else
        if (res_ready_i) state_nx = last ? S_DONE : S_SHIFT;
`endif
      end
      S_SHIFT: begin
        ps_en_o = 1'b1;
        ps_incdec_o = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: state_nx = ps_done_i ? S_SETTLE : tmo ? S_ERR : state;
`ifdef SCAN_AUTO_RETURN_EN
      S_RET_SHIFT: begin
        ps_en_o = 1'b1;
        state_nx = S_RET_WAIT;
      end
      S_RET_WAIT: state_nx = ps_done_i ? (step == '0 ? S_DONE : S_RET_SHIFT) : tmo ? S_ERR : state;
`endif
      S_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // State register
  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) state <= S_IDLE;
    else state <= state_nx;
  end
  // Cycle counter restarts on every state change; step tracks the applied phase offset
  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      cyc <= '0;
      step <= '0;
      cnt <= '0;
      sel <= '0;
      err <= 1'b0;
    end else begin
      cyc <= state_nx != state ? '0 : cyc + CW'(1);
      if (launch) begin
        sel <= sel_i;
        step <= '0;
      end else if (ps_en_o) step <= ps_incdec_o ? step + STEP_BITS'(1) : step - STEP_BITS'(1);
      if (state == S_SETTLE && state_nx == S_SAMPLE) cnt <= '0;
      else if (state == S_SAMPLE) cnt <= cnt + CNT_BITS'(bits[sel]);
      err <= launch ? 1'b0 : (state_nx == S_ERR && state != S_ERR) ? 1'b1 : err;
    end
  end
endmodule
